aes_io_interface: RTL and testbench

Parametrised command-driven front end for the AES core, successor to the byte-serial plaintext/key loader used in front of aes_engine.
- Accepts plaintext and key in DIN_W-bit beats under a 2-bit command and supports 128/192/256-bit keys.
- Issues a start to the AES core, captures the ciphertext and streams it back out with a valid/ready handshake.
- Keeps the loaded key across blocks, so only a new plaintext is needed per encryption.

---
 rtl/aes_io_interface_if.sv | 32 +++
 rtl/aes_io_interface.sv | 158 +++++++++++++++
 tb/tb_aes_io_interface.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_io_interface_if.sv
// rtl/aes_io_interface_if.sv - host load/drain and AES core signal bundle
// The slave modport is the front-end's view; master is the host/core side.
interface aes_io_interface_if #(
   parameter int DIN_W    = 8,
   parameter int KEY_BITS = 128
);
   logic [DIN_W-1:0]    din;
   logic [1:0]          cmd;
   logic                interface_ready;
   logic                cmd_err;
   logic                engine_done;
   logic [DIN_W-1:0]    dout;
   logic                dout_valid;
   logic                dout_ready;
   logic [127:0]        core_pt;
   logic [KEY_BITS-1:0] core_key;
   logic                core_start;
   logic                core_done;
   logic [127:0]        core_ct;

   modport slave (
      input  din, cmd, dout_ready, core_done, core_ct,
      output interface_ready, cmd_err, engine_done, dout, dout_valid,
             core_pt, core_key, core_start
   );

   modport master (
      output din, cmd, dout_ready, core_done, core_ct,
      input  interface_ready, cmd_err, engine_done, dout, dout_valid,
             core_pt, core_key, core_start
   );
endinterface

// File: rtl/aes_io_interface.sv
// rtl/aes_io_interface.sv - command-driven plaintext/key loader and ciphertext drain for the AES core
// The key survives across blocks; each new block needs only a fresh plaintext.
module aes_io_interface #(
   parameter int DIN_W    = 8,
   parameter int KEY_BITS = 128
) (
   input  logic              clk,
   input  logic              rst_,
   aes_io_interface_if.slave io
);
   localparam int PT_BEATS  = 128 / DIN_W;
   localparam int KEY_BEATS = KEY_BITS / DIN_W;
   localparam int PW        = $clog2(PT_BEATS + 1);
   localparam int KW        = $clog2(KEY_BEATS + 1);

   localparam logic [1:0] C_ID = 2'b00;
   localparam logic [1:0] C_SP = 2'b01;
   localparam logic [1:0] C_SK = 2'b10;
   localparam logic [1:0] C_ST = 2'b11;

   typedef enum logic [1:0] {S_LOAD, S_RUN, S_DRAIN, S_DONE} state_e;
   // Last buffer-loading command seen; PV_DONE forces both buffers to restart.
   typedef enum logic [1:0] {PV_NONE, PV_SP, PV_SK, PV_DONE} prev_e;

   state_e              state_q, state_d;
   prev_e               prev_q, prev_d;
   logic [127:0]        pt_q, pt_d;
   logic [127:0]        ct_q, ct_d;
   logic [KEY_BITS-1:0] key_q, key_d;
   logic [PW-1:0]       pt_ptr_q, pt_ptr_d;
   logic [PW-1:0]       out_ptr_q, out_ptr_d;
   logic [KW-1:0]       key_ptr_q, key_ptr_d;
   logic                pt_full_q, pt_full_d;
   logic                key_full_q, key_full_d;
   logic                start_q, start_d;
   logic                err_q, err_d;

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state_q    <= S_LOAD;
         prev_q     <= PV_NONE;
         pt_q       <= '0;
         ct_q       <= '0;
         key_q      <= '0;
         pt_ptr_q   <= '0;
         out_ptr_q  <= '0;
         key_ptr_q  <= '0;
         pt_full_q  <= 1'b0;
         key_full_q <= 1'b0;
         start_q    <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         prev_q     <= prev_d;
         pt_q       <= pt_d;
         ct_q       <= ct_d;
         key_q      <= key_d;
         pt_ptr_q   <= pt_ptr_d;
         out_ptr_q  <= out_ptr_d;
         key_ptr_q  <= key_ptr_d;
         pt_full_q  <= pt_full_d;
         key_full_q <= key_full_d;
         start_q    <= start_d;
         err_q      <= err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      prev_d     = prev_q;
      pt_d       = pt_q;
      ct_d       = ct_q;
      key_d      = key_q;
      pt_ptr_d   = pt_ptr_q;
      out_ptr_d  = out_ptr_q;
      key_ptr_d  = key_ptr_q;
      pt_full_d  = pt_full_q;
      key_full_d = key_full_q;
      start_d    = 1'b0;
      err_d      = 1'b0;

      case (state_q)
         S_LOAD: begin
            case (io.cmd)
               C_SP: begin
                  if (prev_q == PV_SK || prev_q == PV_DONE) begin
                     pt_ptr_d  = '0;
                     pt_full_d = 1'b0;
                  end
                  // Once full, extra beats are dropped rather than wrapping.
                  if (!pt_full_d) begin
                     pt_d[127 - int'(pt_ptr_d) * DIN_W -: DIN_W] = io.din;
                     pt_full_d = (pt_ptr_d == PW'(PT_BEATS - 1));
                     pt_ptr_d  = pt_ptr_d + PW'(1);
                  end
                  prev_d = PV_SP;
               end
               C_SK: begin
                  if (prev_q == PV_SP || prev_q == PV_DONE) begin
                     key_ptr_d  = '0;
                     key_full_d = 1'b0;
                  end
                  if (!key_full_d) begin
                     key_d[KEY_BITS - 1 - int'(key_ptr_d) * DIN_W -: DIN_W] = io.din;
                     key_full_d = (key_ptr_d == KW'(KEY_BEATS - 1));
                     key_ptr_d  = key_ptr_d + KW'(1);
                  end
                  prev_d = PV_SK;
               end
               C_ST: begin
                  if (pt_full_q && key_full_q) begin
                     state_d = S_RUN;
                     start_d = 1'b1;
                  end else begin
                     err_d = 1'b1;
                  end
               end
               default: ;
            endcase
         end
         S_RUN: begin
            // A done pulse coincident with our own start pulse is stale.
            if (io.core_done && !start_q) begin
               ct_d      = io.core_ct;
               out_ptr_d = '0;
               state_d   = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (io.dout_ready) begin
               if (out_ptr_q == PW'(PT_BEATS - 1)) begin
                  out_ptr_d = '0;
                  state_d   = S_DONE;
               end else begin
                  out_ptr_d = out_ptr_q + PW'(1);
               end
            end
         end
         S_DONE: begin
            if (io.cmd == C_ID) begin
               state_d   = S_LOAD;
               pt_full_d = 1'b0;
               prev_d    = PV_DONE;
            end
         end
         default: state_d = S_LOAD;
      endcase
   end

   assign io.interface_ready = (state_q == S_LOAD);
   assign io.cmd_err         = err_q;
   assign io.engine_done     = (state_q == S_DONE);
   assign io.dout_valid      = (state_q == S_DRAIN);
   assign io.dout            = (state_q == S_DRAIN) ? ct_q[127 - int'(out_ptr_q) * DIN_W -: DIN_W] : '0;
   assign io.core_pt         = pt_q;
   assign io.core_key        = key_q;
   assign io.core_start      = start_q;
endmodule

// File: tb/tb_aes_io_interface.sv
// tb/tb_aes_io_interface.sv - scoreboard bench for aes_io_interface (8/128 and 32/256 instances)
module tb_aes_io_interface;
   localparam logic [1:0] C_ID = 2'b00;
   localparam logic [1:0] C_SP = 2'b01;
   localparam logic [1:0] C_SK = 2'b10;
   localparam logic [1:0] C_ST = 2'b11;

   localparam logic [127:0] PT1  = 128'h00041214120412000C00131108231919;
   localparam logic [127:0] KEY1 = 128'h2475A2B33475568831E2120013AA5487;
   localparam logic [127:0] CT1  = 128'h00112233445566778899AABBCCDDEEFF;
   localparam logic [127:0] PT2  = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
   localparam logic [127:0] CT2  = 128'hFEDCBA98765432100123456789ABCDEF;
   localparam logic [127:0] PT3  = 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF;
   localparam logic [127:0] CT3  = 128'h5A5A0F0FC3C3969601020408102040FF;
   localparam logic [127:0] JUNK = 128'hDEADDEADDEADDEADDEADDEADDEADDEAD;
   localparam logic [127:0] PTB  = 128'h3243F6A8885A308D313198A2E0370734;
   localparam logic [255:0] KEYB = 256'h000102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F;
   localparam logic [127:0] CTB  = 128'h8EA2B7CA516745BFEAFC49904B496089;
   localparam logic [127:0] PTC  = 128'h00112233445566778899AABBCCDDEEFF;
   localparam logic [127:0] CTC  = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;

   logic clk = 1'b0;
   logic rst_ = 1'b0;
   always #5 clk = ~clk;

   aes_io_interface_if #(.DIN_W(8),  .KEY_BITS(128)) if0 ();
   aes_io_interface_if #(.DIN_W(32), .KEY_BITS(256)) if1 ();

   aes_io_interface #(.DIN_W(8),  .KEY_BITS(128)) u0 (.clk(clk), .rst_(rst_), .io(if0.slave));
   aes_io_interface #(.DIN_W(32), .KEY_BITS(256)) u1 (.clk(clk), .rst_(rst_), .io(if1.slave));

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Scoreboard queues filled when a core result is issued; monitors pop on each transfer.
   logic [7:0]  exp0[$];
   logic [31:0] exp1[$];
   int xfer0 = 0, xfer1 = 0, vcnt0 = 0, vcnt1 = 0;
   bit stall0 = 1'b0, stall1 = 1'b0;
   logic [7:0]  hold0;
   logic [31:0] hold1;

   always @(negedge clk) begin
      if (stall0) chk("dout0_hold", {if0.dout_valid, if0.dout}, {1'b1, hold0});
      if (if0.dout_valid) vcnt0++;
      if (if0.dout_valid && if0.dout_ready) begin
         xfer0++;
         if (exp0.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL dout0_extra: got beat %0h expected no beat", if0.dout);
         end else chk("dout0_beat", if0.dout, exp0.pop_front());
      end
      stall0 = if0.dout_valid && !if0.dout_ready;
      hold0  = if0.dout;
   end

   always @(negedge clk) begin
      if (stall1) chk("dout1_hold", {if1.dout_valid, if1.dout}, {1'b1, hold1});
      if (if1.dout_valid) vcnt1++;
      if (if1.dout_valid && if1.dout_ready) begin
         xfer1++;
         if (exp1.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL dout1_extra: got beat %0h expected no beat", if1.dout);
         end else chk("dout1_beat", if1.dout, exp1.pop_front());
      end
      stall1 = if1.dout_valid && !if1.dout_ready;
      hold1  = if1.dout;
   end

   task automatic step0(input logic [1:0] c, input logic [7:0] d);
      if0.cmd = c; if0.din = d;
      @(posedge clk); #1;
   endtask

   task automatic step1(input logic [1:0] c, input logic [31:0] d);
      if1.cmd = c; if1.din = d;
      @(posedge clk); #1;
   endtask

   task automatic load0(input logic [1:0] c, input logic [127:0] v, input int first, input int last);
      for (int i = first; i < last; i++) step0(c, v[127 - 8 * i -: 8]);
   endtask

   task automatic load1(input logic [1:0] c, input logic [255:0] v, input int first, input int last);
      for (int i = first; i < last; i++) step1(c, v[255 - 32 * i -: 32]);
   endtask

   // Model core returns ct, drain with a repeating ready pattern, then exit DONE.
   task automatic run0(input logic [127:0] ct, input logic [3:0] pat, input int nvalid);
      int x0, v0, n;
      x0 = xfer0; v0 = vcnt0; n = 0;
      repeat (2) step0(C_SP, 8'h55);
      if0.core_done = 1'b1; if0.core_ct = ct;
      for (int i = 0; i < 16; i++) exp0.push_back(ct[127 - 8 * i -: 8]);
      step0(C_SP, 8'h55);
      if0.core_done = 1'b0; if0.core_ct = '0;
      while (!if0.engine_done && n < 200) begin
         if0.dout_ready = pat[3 - n % 4];
         step0(C_SP, 8'h55);
         n++;
      end
      if0.dout_ready = 1'b0;
      chk("drain0_done", if0.engine_done, 1'b1);
      chk("drain0_xfers", xfer0 - x0, 16);
      chk("drain0_valid_cycles", vcnt0 - v0, nvalid);
      chk("drain0_queue_empty", exp0.size(), 0);
      step0(C_ST, 8'h00);
      chk("done0_st_no_retrigger", {if0.engine_done, if0.core_start}, 2'b10);
      step0(C_ID, 8'h00);
      chk("done0_exit", {if0.interface_ready, if0.engine_done}, 2'b10);
   endtask

   task automatic run1(input logic [127:0] ct);
      int x1, n;
      x1 = xfer1; n = 0;
      repeat (2) step1(C_SP, 32'h0);
      if1.core_done = 1'b1; if1.core_ct = ct;
      for (int i = 0; i < 4; i++) exp1.push_back(ct[127 - 32 * i -: 32]);
      step1(C_SP, 32'h0);
      if1.core_done = 1'b0; if1.core_ct = '0;
      if1.dout_ready = 1'b1;
      while (!if1.engine_done && n < 50) begin
         step1(C_SP, 32'h0);
         n++;
      end
      if1.dout_ready = 1'b0;
      chk("drain1_cycles", n, 4);
      chk("drain1_xfers", xfer1 - x1, 4);
      step1(C_ID, 32'h0);
      chk("done1_exit", if1.interface_ready, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1);
   end

   initial begin
      int xr;
      if0.cmd = C_ID; if0.din = '0; if0.dout_ready = 1'b0; if0.core_done = 1'b0; if0.core_ct = '0;
      if1.cmd = C_ID; if1.din = '0; if1.dout_ready = 1'b0; if1.core_done = 1'b0; if1.core_ct = '0;
      #3;
      chk("reset_ctrl", {if0.interface_ready, if0.cmd_err, if0.engine_done, if0.dout_valid, if0.core_start}, 5'b10000);
      chk("reset_regs", {if0.core_pt, if0.core_key}, 256'h0);
      @(posedge clk); #1;
      rst_ = 1'b1;

      // 32/256: key_full only after the 8th word, 9th word ignored
      load1(C_SP, {PTB, 128'h0}, 0, 4);
      load1(C_SK, KEYB, 0, 7);
      step1(C_ST, 32'h0);
      chk("k256_err_7words", {if1.cmd_err, if1.core_start}, 2'b10);
      load1(C_SK, KEYB, 7, 8);
      step1(C_SK, 32'hCAFEF00D);
      step1(C_ST, 32'h0);
      chk("k256_start", {if1.core_start, if1.interface_ready}, 2'b10);
      chk("k256_core_key", if1.core_key, KEYB);
      chk("k256_core_pt", if1.core_pt, PTB);
      run1(CTB);
      load1(C_SP, {PTC, 128'h0}, 0, 4);
      step1(C_ST, 32'h0);
      chk("k256_reuse_start", if1.core_start, 1'b1);
      chk("k256_reuse_key", if1.core_key, KEYB);
      chk("k256_reuse_pt", if1.core_pt, PTC);
      run1(CTC);

      // 8/128 basic load, start, full-rate drain
      load0(C_SP, PT1, 0, 16);
      load0(C_SK, KEY1, 0, 16);
      step0(C_ST, 8'h00);
      chk("t1_start", {if0.core_start, if0.interface_ready, if0.cmd_err}, 3'b100);
      chk("t1_core_pt", if0.core_pt, PT1);
      chk("t1_core_key", if0.core_key, KEY1);
      step0(C_SP, 8'hAA);
      chk("t1_start_one_cycle", if0.core_start, 1'b0);
      run0(CT1, 4'b1111, 16);
      chk("t1_pt_stable", if0.core_pt, PT1);

      // new plaintext only, stalled drain
      load0(C_SP, PT2, 0, 16);
      step0(C_ST, 8'h00);
      chk("t2_start", if0.core_start, 1'b1);
      chk("t2_core_pt", if0.core_pt, PT2);
      chk("t2_key_kept", if0.core_key, KEY1);
      step0(C_SP, 8'h00);
      run0(CT2, 4'b1001, 32);

      // premature start, resumed load, stale done in the start cycle
      load0(C_SP, PT3, 0, 10);
      step0(C_ST, 8'h00);
      chk("t3_err", {if0.cmd_err, if0.core_start, if0.interface_ready}, 3'b101);
      step0(C_ID, 8'h00);
      chk("t3_err_one_cycle", if0.cmd_err, 1'b0);
      step0(C_ID, 8'h00);
      load0(C_SP, PT3, 10, 16);
      step0(C_ST, 8'h00);
      chk("t3_start", if0.core_start, 1'b1);
      chk("t3_core_pt", if0.core_pt, PT3);
      if0.core_done = 1'b1; if0.core_ct = JUNK;
      step0(C_SP, 8'h00);
      if0.core_done = 1'b0; if0.core_ct = '0;
      chk("t3_stale_done_ignored", {if0.dout_valid, if0.engine_done}, 2'b00);
      run0(CT3, 4'b1111, 16);

      // reset in the middle of a drain
      load0(C_SP, PT1, 0, 16);
      step0(C_ST, 8'h00);
      step0(C_SP, 8'h00);
      if0.core_done = 1'b1; if0.core_ct = CT1;
      for (int i = 0; i < 16; i++) exp0.push_back(CT1[127 - 8 * i -: 8]);
      step0(C_SP, 8'h00);
      if0.core_done = 1'b0; if0.core_ct = '0;
      xr = xfer0;
      if0.dout_ready = 1'b1;
      repeat (5) step0(C_SP, 8'h00);
      chk("t6_xfers_before_reset", xfer0 - xr, 5);
      rst_ = 1'b0;
      #1;
      chk("t6_rst_ctrl", {if0.interface_ready, if0.cmd_err, if0.engine_done, if0.dout_valid, if0.core_start}, 5'b10000);
      chk("t6_rst_dout", if0.dout, 8'h00);
      chk("t6_rst_regs", {if0.core_pt, if0.core_key}, 256'h0);
      chk("t6_pending_beats", exp0.size(), 11);
      exp0.delete();
      if0.dout_ready = 1'b0;
      @(posedge clk); #1;
      rst_ = 1'b1;
      if0.core_done = 1'b1; if0.core_ct = CT1;
      step0(C_ID, 8'h00);
      if0.core_done = 1'b0; if0.core_ct = '0;
      chk("t6_late_done_ignored", {if0.interface_ready, if0.dout_valid}, 2'b10);
      step0(C_ST, 8'h00);
      chk("t6_err_after_reset", {if0.cmd_err, if0.core_start}, 2'b10);
      step0(C_ID, 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
